conv_frame_sequencer: RTL

//  Frame-level controller for the rate-1/2, K=7 convolutional encoder datapath.
//  - Takes a frame length and payload bits over a valid/ready stream.
//  - Steps the encoder once per accepted bit, then appends K-1 zero tail bits to flush it.
//  - Emits one coded symbol pair per step with backpressure and frame delimiting.
//  - Sits between the bit source (scrambler/MAC) and the modulator symbol mapper.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_enc_core.sv | 30 +++
 rtl/conv_frame_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the K=7 rate-1/2 convolutional encoder frame path.
package conv_pkg;

    localparam int unsigned K          = 7;
    localparam int unsigned TAIL_LEN   = K - 1;
    localparam int unsigned TAIL_CNT_W = $clog2(TAIL_LEN + 1);

    // Generator polynomials; MSB taps the current input bit.
    localparam logic [K-1:0] G1_POLY = 7'o171;
    localparam logic [K-1:0] G0_POLY = 7'o133;

    // Rate-2/3 keep masks: [1:0] for even steps, [3:2] for odd steps (G0 dropped).
    localparam logic [3:0] PUNCT_PAT = 4'b10_11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        TAIL    = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/conv_enc_core.sv
// K=7 convolutional encoder core: K-1 bit shift register plus combinational G1/G0 pair.
module conv_enc_core
    import conv_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_step,
    input  logic       i_bit,
    output logic [1:0] o_pair_c
);

    logic [TAIL_LEN-1:0] r_sr;
    logic [K-1:0]        w_win;

    // Shift register: newest bit enters at the MSB; clear has priority over a step.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr <= '0;
        end else if (i_clr) begin
            r_sr <= '0;
        end else if (i_step) begin
            r_sr <= {i_bit, r_sr[TAIL_LEN-1:1]};
        end
    end

    assign w_win    = {i_bit, r_sr};
    assign o_pair_c = {^(w_win & G1_POLY), ^(w_win & G0_POLY)};

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the K=7 convolutional encoder: payload steps, zero tail flush,
// registered symbol output with valid/ready backpressure and frame delimiting.
// Optional build macro: CONV_PUNCTURE_EN (rate-2/3 keep mask on out_mask).
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned LEN_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_frame_len,
    output logic             o_busy,
    input  logic             i_in_valid,
    input  logic             i_in_bit,
    output logic             o_in_ready,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [1:0]       o_x_encoded,
    output logic [1:0]       o_out_mask,
    output logic             o_out_last,
    output logic             o_done
);

    seq_state_t            r_state, w_state_nxt;
    logic [LEN_W-1:0]      r_bits_left, w_bits_left_nxt;
    logic [TAIL_CNT_W-1:0] r_tail_left, w_tail_left_nxt;
    logic                  r_busy, r_done;
    logic                  r_out_valid, r_out_last;
    logic [1:0]            r_x_encoded, r_out_mask;
    logic                  w_step_en, w_step, w_clr, w_in_ready, w_enc_bit, w_last;
    logic [1:0]            w_pair, w_mask;

    conv_enc_core u_enc (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_clr),
        .i_step   (w_step),
        .i_bit    (w_enc_bit),
        .o_pair_c (w_pair)
    );

    // Next-state, counter updates and step generation.
    always_comb begin
        w_state_nxt     = r_state;
        w_bits_left_nxt = r_bits_left;
        w_tail_left_nxt = r_tail_left;
        w_step_en       = !r_out_valid || i_out_ready;
        w_step          = 1'b0;
        w_clr           = 1'b0;
        w_in_ready      = 1'b0;
        w_enc_bit       = 1'b0;
        w_last          = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_clr           = 1'b1;
                    w_bits_left_nxt = i_frame_len;
                    w_tail_left_nxt = TAIL_CNT_W'(TAIL_LEN);
                    w_state_nxt     = (i_frame_len != '0) ? PAYLOAD : TAIL;
                end
            end
            PAYLOAD: begin
                w_in_ready = w_step_en;
                w_enc_bit  = i_in_bit;
                if (i_in_valid && w_step_en) begin
                    w_step          = 1'b1;
                    w_bits_left_nxt = r_bits_left - LEN_W'(1);
                    if (r_bits_left == LEN_W'(1)) begin
                        w_state_nxt = TAIL;
                    end
                end
            end
            TAIL: begin
                // Step the zero tail; once exhausted, wait for the last symbol to drain.
                if (r_tail_left != '0) begin
                    if (w_step_en) begin
                        w_step          = 1'b1;
                        w_tail_left_nxt = r_tail_left - TAIL_CNT_W'(1);
                        w_last          = (r_tail_left == TAIL_CNT_W'(1));
                    end
                end else if (r_out_valid && r_out_last && i_out_ready) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered status flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_bits_left <= '0;
            r_tail_left <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bits_left <= w_bits_left_nxt;
            r_tail_left <= w_tail_left_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == DONE);
        end
    end

`ifdef CONV_PUNCTURE_EN
    logic r_parity;

    // Step parity selects the keep mask; restarts at every frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_parity <= 1'b0;
        end else if (w_clr) begin
            r_parity <= 1'b0;
        end else if (w_step) begin
            r_parity <= ~r_parity;
        end
    end

    assign w_mask = r_parity ? PUNCT_PAT[3:2] : PUNCT_PAT[1:0];
`else
    assign w_mask = 2'b11;
`endif

    // Output symbol register: loads on a step, drops valid once accepted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_x_encoded <= 2'b00;
            r_out_mask  <= 2'b00;
        end else if (w_step) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_last;
            r_x_encoded <= w_pair;
            r_out_mask  <= w_mask;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
    assign o_x_encoded = r_x_encoded;
    assign o_out_mask  = r_out_mask;

endmodule
